// File: rtl/show_display.sv
// rtl/show_display.sv - show-channel byte latch driving a 4-digit multiplexed hex 7-segment display
// Optional leading-zero blanking is compiled in when SHOW_LZB_EN is defined.
module show_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Show,
  input  logic [7:0] ShowData,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [7:0] write_cnt
);

  localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] disp_q, disp_d;
  logic [15:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  write_cnt_q, write_cnt_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    disp_d      = disp_q;
    write_cnt_d = write_cnt_q;
    pre_d       = pre_q + 16'd1;
    idx_d       = idx_q;

    case (Show)
      2'b01:   disp_d[7:0]  = ShowData;
      2'b10:   disp_d[15:8] = ShowData;
      2'b11:   disp_d       = 16'h0000;
      default: disp_d       = disp_q;
    endcase
    if (Show != 2'b00) write_cnt_d = write_cnt_q + 8'd1;

    if (pre_q == PRE_MAX) begin
      pre_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end

    // Outputs follow next-state idx/disp so a write shows on the same edge.
    case (idx_d)
      2'd0:    nib = disp_d[3:0];
      2'd1:    nib = disp_d[7:4];
      2'd2:    nib = disp_d[11:8];
      default: nib = disp_d[15:12];
    endcase

`ifdef SHOW_LZB_EN
    blank = ((idx_d == 2'd3) && (disp_d[15:12] == 4'h0)) ||
            ((idx_d == 2'd2) && (disp_d[15:8] == 8'h00)) ||
            ((idx_d == 2'd1) && (disp_d[15:4] == 12'h000));
`else
    blank = 1'b0;
`endif

    seg_d = blank ? 7'b1111111 : hex7(nib);
    an_d  = ~(4'b0001 << idx_d);
    dp_d  = !((idx_d == 2'd2) && !blank);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q      <= 16'h0000;
      pre_q       <= 16'd0;
      idx_q       <= 2'd0;
      write_cnt_q <= 8'd0;
      seg_q       <= 7'b1000000;
      an_q        <= 4'b1110;
      dp_q        <= 1'b1;
    end else begin
      disp_q      <= disp_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      write_cnt_q <= write_cnt_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign write_cnt = write_cnt_q;

endmodule

// File: tb/tb_show_display.sv
// tb/tb_show_display.sv - randomized bench for show_display against a frame-counting reference model
// Model expectations follow SHOW_LZB_EN the same way the design does.
module tb_show_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Show;
  logic [7:0] ShowData;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [7:0] write_cnt;

  int total = 0;
  int bad   = 0;

  int m_disp = 0;
  int m_cnt  = 0;
  int m_cyc  = 0;
  logic [6:0] hex_tab [16];

  show_display #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .Show(Show), .ShowData(ShowData),
    .seg(seg), .an(an), .dp(dp), .write_cnt(write_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int idx, upper, nib;
    logic blank;
    idx   = (m_cyc / DIV) % 4;
    upper = m_disp >> (4 * idx);
    nib   = upper & 15;
`ifdef SHOW_LZB_EN
    blank = (idx != 0) && (upper == 0);
`else
    blank = 1'b0;
`endif
    chk("an", 32'(an), 32'((~(1 << idx)) & 15));
    chk("seg", 32'(seg), blank ? 32'h7F : 32'(hex_tab[nib]));
    chk("dp", 32'(dp), (idx == 2 && !blank) ? 32'd0 : 32'd1);
    chk("write_cnt", 32'(write_cnt), 32'(m_cnt));
  endtask

  // Called at a negedge: drives inputs, applies the model for the next rising edge, checks after it.
  task automatic step(input logic r, input logic [1:0] s, input logic [7:0] d);
    reset = r; Show = s; ShowData = d;
    @(posedge clk);
    if (r) begin
      m_disp = 0; m_cnt = 0; m_cyc = 0;
    end else begin
      case (s)
        2'b01: m_disp = (m_disp & 32'hFF00) | int'(d);
        2'b10: m_disp = (m_disp & 32'h00FF) | (int'(d) << 8);
        2'b11: m_disp = 0;
        default: ;
      endcase
      if (s != 2'b00) m_cnt = (m_cnt + 1) % 256;
      m_cyc++;
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010; hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

    reset = 1'b1; Show = 2'b00; ShowData = 8'h00;
    @(negedge clk);
    step(1'b1, 2'b00, 8'h00);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_cnt", 32'(write_cnt), 32'd0);

    for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 8'h00);

    step(1'b0, 2'b01, 8'h3A);
    step(1'b0, 2'b10, 8'hF5);
    chk("cnt_two", 32'(write_cnt), 32'd2);
    for (int i = 0; i < 4 * DIV; i++) step(1'b0, 2'b00, 8'h00);

    step(1'b0, 2'b11, 8'hFF);
    chk("cnt_clear", 32'(write_cnt), 32'd3);
    for (int i = 0; i < 4 * DIV; i++) step(1'b0, 2'b00, 8'h00);

    step(1'b0, 2'b01, 8'h0C);
    for (int i = 0; i < 4 * DIV; i++) step(1'b0, 2'b00, 8'h00);

    step(1'b1, 2'b00, 8'h00);
    for (int i = 0; i < 256; i++) step(1'b0, 2'b01, 8'(i));
    chk("cnt_wrap", 32'(write_cnt), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 8'h77);
    step(1'b1, 2'b01, 8'hAB);
    chk("midrst_an", 32'(an), 32'b1110);
    chk("midrst_seg", 32'(seg), 32'b1000000);
    chk("midrst_dp", 32'(dp), 32'd1);
    chk("midrst_cnt", 32'(write_cnt), 32'd0);
    for (int i = 0; i < 4 * DIV; i++) step(1'b0, 2'b00, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic [1:0] s;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if (s == 2'b11 && $urandom_range(0, 3) != 0) s = 2'b00;
      step(r, s, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/show_display.md
# show_display

Display back end for the single-cycle processor. Consumes the core's `Show`/`ShowData` output strobe, latches shown bytes into a 16-bit display register and drives a time-multiplexed 4-digit common-anode 7-segment display in hexadecimal. It sits directly downstream of the CPU and is the only consumer of its show channel.

## Interface

- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range 1..65535.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Show`  in  2  show command from the CPU: 00 none, 01 write low byte, 10 write high byte, 11 clear.
- `ShowData`  in  8  byte to show; sampled only when `Show` is 01 or 10.
- `seg`  out  7  segment drive {g,f,e,d,c,b,a}; active-low; registered.
- `an`  out  4  digit enable; active-low, one-hot-low; registered.
- `dp`  out  1  decimal point; active-low; registered.
- `write_cnt`  out  8  count of accepted commands 01/10/11; wraps 255→0.

## Operation

- Display register `disp[15:0]`:
  - 01: `disp[7:0]` ← `ShowData`.
  - 10: `disp[15:8]` ← `ShowData`.
  - 11: `disp` ← 0.
  - 00: hold.
- `write_cnt` increments by one on every non-00 command.
- Digit map:
  - digit 0 (`an[0]`) = `disp[3:0]`.
  - digit 1 = `disp[7:4]`.
  - digit 2 = `disp[11:8]`.
  - digit 3 = `disp[15:12]`.
- Hex decode, active-low: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Scan:
  - Prescaler `pre` counts 0..SCAN_DIV-1.
  - When `pre`==SCAN_DIV-1, `pre` wraps to 0 and digit index `idx` advances 0→1→2→3→0.
  - With SCAN_DIV=1, `idx` advances every cycle.
- Output register: every cycle, `an`, `seg`, `dp` load from next-state `idx` and next-state `disp`.
- `dp` is 0 only while digit 2 is selected (byte separator).
- Simultaneous write and digit advance: the new digit shows the newly written value.
- Undefined `Show` (X) is outside this block's contract.

## Timing

- Reset values:
  - `disp`=0, `pre`=0, `idx`=0, `write_cnt`=0.
  - `an`=1110, `seg`=1000000, `dp`=1.
- Reset mid-scan or mid-command: all state returns to the reset values on that edge. A `Show` command presented in the same cycle as `reset` is discarded.
- Write latency: a command present at edge N updates `disp` and `write_cnt` at edge N. `seg` reflects the new value at edge N, because outputs load from next-state `disp`, provided the affected digit is selected.
- Digit dwell: exactly SCAN_DIV cycles per digit; full frame is 4×SCAN_DIV cycles.
- `an` is never all-ones and never has two zeros after reset.

## Configuration

- `SHOW_LZB_EN` defined: leading-zero blanking is compiled in.
  - Digit k (k=3..1) is blanked (`seg`=1111111) when it and all higher digits are zero.
  - Digit 0 is never blanked.
  - `dp` on digit 2 is forced to 1 when digit 2 is blanked.
  - `an` scanning is unchanged.
- `SHOW_LZB_EN` undefined: all four digits always display, including leading zeros.

## Test plan

- Reset, SCAN_DIV=4 → `an`=1110, `seg`=1000000, `dp`=1, `write_cnt`=0. `an` sequence 1110,1101,1011,0111 at 4-cycle intervals, repeating.
- `Show`=01, `ShowData`=8'h3A, then `Show`=10, `ShowData`=8'hF5 → `disp`=16'hF53A. Digits 0..3 show A, 3, 5, F. `dp`=0 only on digit 2. `write_cnt`=2.
- `Show`=11 with `ShowData`=8'hFF → `disp`=0, `write_cnt`+1, ShowData ignored.
- 256 consecutive `Show`=01 commands → `write_cnt` wraps to 0.
- `SHOW_LZB_EN` defined, `disp`=16'h000C → digits 3..1 `seg`=1111111, digit 0 `seg`=1000110, `dp`=1 throughout.
- `reset` asserted mid-dwell with `Show`=01 in the same cycle → all outputs at reset values on that edge, `disp` remains 0.
